vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: horizontal and vertical counters with registered sync, blanking and frame/line markers. Replaces the standalone horizontal counter and sits between the board clock and the pixel/character renderer, which consumes `hcount`, `vcount` and `video_on`. It supports any mode expressible as active/front-porch/sync/back-porch per axis with selectable sync polarity. The default parameters give 640x480@60 (800x525 total).

---
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between vga_timing_gen and the pixel renderer
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          en;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_start;
  logic          frame_start;

  // master: the timing generator; slave: the renderer that consumes the raster position
  modport master (
    input  en,
    output hcount, vcount, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    output en,
    input  hcount, vcount, hsync, vsync, video_on, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster counters with registered sync/blank/markers
// Optional Clk/2 pixel divider: define VGA_TIMING_PIXDIV_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic           Clk,
  input  logic           reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ACT     = (HS_POL != 0);
  localparam logic          VS_ACT     = (VS_POL != 0);

  logic tick;
  logic adv;

`ifdef VGA_TIMING_PIXDIV_EN
  logic div_q;

  // Starts at 0 so the first advance after release happens on the second Clk.
  always_ff @(posedge Clk) begin
    if (reset) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign tick = div_q;
`else
  assign tick = 1'b1;
`endif

  assign adv = vga.en & tick;

  logic [CW-1:0] hcount_q;
  logic [CW-1:0] vcount_q;
  logic          hsync_q;
  logic          vsync_q;
  logic          video_on_q;
  logic          line_start_q;
  logic          frame_start_q;

  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          hs_on;
  logic          vs_on;
  logic          vis_next;

  // Everything is decoded from the next position so the registered outputs line up with the counters.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    h_next   = h_wrap ? '0 : hcount_q + 1'b1;
    v_next   = vcount_q;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount_q + 1'b1;
    end
    hs_on    = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    vs_on    = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    vis_next = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (adv) begin
      hcount_q      <= h_next;
      vcount_q      <= v_next;
      hsync_q       <= hs_on ? HS_ACT : ~HS_ACT;
      vsync_q       <= vs_on ? VS_ACT : ~VS_ACT;
      video_on_q    <= vis_next;
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap & v_wrap;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default mode and a tiny mode)
module tb_vga_timing_gen;

  logic Clk   = 1'b0;
  logic reset = 1'b1;

  vga_timing_gen_if #(.CW(10)) dif ();
  vga_timing_gen_if #(.CW(10)) sif ();

  vga_timing_gen #(.CW(10)) dut_d (
    .Clk   (Clk),
    .reset (reset),
    .vga   (dif.master)
  );

  // Tiny mode: 23 x 11 total, positive hsync, so whole frames fit in a short run.
  vga_timing_gen #(
    .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(6),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1), .VS_POL(0), .CW(10)
  ) dut_s (
    .Clk   (Clk),
    .reset (reset),
    .vga   (sif.master)
  );

  always #5 Clk = ~Clk;

`ifdef VGA_TIMING_PIXDIV_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif
  localparam int HTD = 800, VTD = 525, HTS = 23, VTS = 11;

  int checks = 0;
  int errors = 0;

  // Model: linear position within the frame, plus pulse flags and the divider phase.
  int   p_d, p_s;
  logic ls_d, fs_d, ls_s, fs_s;
  logic mdiv;
  logic [24:0] exp_d, exp_s;

  wire [24:0] obs_d = {dif.hcount, dif.vcount, dif.hsync, dif.vsync,
                       dif.video_on, dif.line_start, dif.frame_start};
  wire [24:0] obs_s = {sif.hcount, sif.vcount, sif.hsync, sif.vsync,
                       sif.video_on, sif.line_start, sif.frame_start};

  function automatic logic [24:0] ref_vec(input int p, input logic ls, input logic fs,
                                          input int ha, input int hf, input int hsw, input int hb,
                                          input int va, input int vf, input int vsw, input int vb,
                                          input logic hp, input logic vp);
    int h, v, ht;
    logic hs, vs, vo;
    logic [9:0] hv, vv;
    ht = ha + hf + hsw + hb;
    h  = p % ht;
    v  = p / ht;
    hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    vo = (h < ha) && (v < va);
    hv = h[9:0];
    vv = v[9:0];
    return {hv, vv, hs, vs, vo, ls, fs};
  endfunction

  task automatic step(input logic rst, input logic ed, input logic es);
    logic tick;
    @(negedge Clk);
    reset  = rst;
    dif.en = ed;
    sif.en = es;
    @(posedge Clk);
    if (rst) begin
      p_d = HTD * VTD - 1; p_s = HTS * VTS - 1;
      ls_d = 0; fs_d = 0; ls_s = 0; fs_s = 0;
      mdiv = 0;
    end else begin
      tick = (K == 2) ? mdiv : 1'b1;
      mdiv = ~mdiv;
      if (ed && tick) begin
        p_d  = (p_d + 1) % (HTD * VTD);
        ls_d = (p_d % HTD == 0);
        fs_d = (p_d == 0);
      end else begin
        ls_d = 0; fs_d = 0;
      end
      if (es && tick) begin
        p_s  = (p_s + 1) % (HTS * VTS);
        ls_s = (p_s % HTS == 0);
        fs_s = (p_s == 0);
      end else begin
        ls_s = 0; fs_s = 0;
      end
    end
    exp_d = ref_vec(p_d, ls_d, fs_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    exp_s = ref_vec(p_s, ls_s, fs_s, 12, 2, 3, 6, 6, 1, 2, 2, 1'b1, 1'b0);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 1);
    checks++;
    if (obs_d !== exp_d) begin errors++; $display("FAIL reset_d got=%h want=%h", obs_d, exp_d); end
    checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL reset_s got=%h want=%h", obs_s, exp_s); end
    checks++;
    if (dif.hcount !== 10'd799 || dif.vcount !== 10'd524) begin
      errors++; $display("FAIL reset_pos got=(%0d,%0d) want=(799,524)", dif.hcount, dif.vcount);
    end
    checks++;
    if ({dif.hsync, dif.vsync, dif.video_on, dif.line_start, dif.frame_start} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=11000",
               {dif.hsync, dif.vsync, dif.video_on, dif.line_start, dif.frame_start});
    end
    checks++;
    if (sif.hsync !== 1'b0) begin errors++; $display("FAIL reset_hs_pos got=%b want=0", sif.hsync); end
  endtask

  task automatic test_first_lines();
    int hmax = 0;
    int last_ls = -1;
    bit first = 1;
    for (int i = 0; i < 1700 * K; i++) begin
      step(0, 1, 0);
      checks++;
      if (obs_d !== exp_d) begin errors++; $display("FAIL lines i=%0d got=%h want=%h", i, obs_d, exp_d); end
      if (first && fs_d) begin
        first = 0;
        checks++;
        if (obs_d !== {10'd0, 10'd0, 5'b11111}) begin
          errors++; $display("FAIL first_adv got=%h want=%h", obs_d, {10'd0, 10'd0, 5'b11111});
        end
      end
      if (int'(dif.hcount) > hmax) hmax = int'(dif.hcount);
      if (p_d % HTD == 656) begin
        checks++;
        if (dif.hsync !== 1'b0) begin errors++; $display("FAIL hs_fall got=%b want=0", dif.hsync); end
      end
      if (p_d % HTD == 752) begin
        checks++;
        if (dif.hsync !== 1'b1) begin errors++; $display("FAIL hs_rise got=%b want=1", dif.hsync); end
      end
      if (p_d % HTD == 640) begin
        checks++;
        if (dif.video_on !== 1'b0) begin errors++; $display("FAIL vo_h640 got=%b want=0", dif.video_on); end
      end
      if (dif.line_start === 1'b1) begin
        if (last_ls >= 0) begin
          checks++;
          if (i - last_ls != HTD * K) begin
            errors++; $display("FAIL line_len got=%0d want=%0d", i - last_ls, HTD * K);
          end
        end
        last_ls = i;
      end
    end
    checks++;
    if (hmax != 799) begin errors++; $display("FAIL hmax got=%0d want=799", hmax); end
  endtask

  task automatic test_freeze();
    int n = 0;
    while (p_d % HTD != 100 && n < 2000 * K) begin step(0, 1, 1); n++; end
    checks++;
    if (p_d % HTD != 100) begin errors++; $display("FAIL freeze_reach got=%0d want=100", p_d % HTD); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      checks++;
      if (obs_d !== exp_d || dif.hcount !== 10'd100) begin
        errors++; $display("FAIL freeze_hold got=%h want=%h", obs_d, exp_d);
      end
    end
    n = 0;
    while (p_d % HTD == 100 && n < 4) begin step(0, 1, 1); n++; end
    checks++;
    if (dif.hcount !== 10'd101 || obs_d !== exp_d) begin
      errors++; $display("FAIL freeze_resume got=%0d want=101", dif.hcount);
    end
    n = 0;
    while (!ls_s && n < 100) begin step(0, 0, 1); n++; end
    checks++;
    if (sif.line_start !== 1'b1) begin errors++; $display("FAIL ls_reach got=%b want=1", sif.line_start); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      checks++;
      if (sif.line_start !== 1'b0 || obs_s !== exp_s) begin
        errors++; $display("FAIL ls_frozen got=%h want=%h", obs_s, exp_s);
      end
    end
  endtask

  task automatic test_frame_count();
    int fcount = 0, lcount = 0, last_fs = -1;
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 1; i <= 4 * HTS * VTS * K; i++) begin
      step(0, 1, 1);
      checks++;
      if (obs_s !== exp_s) begin errors++; $display("FAIL frame i=%0d got=%h want=%h", i, obs_s, exp_s); end
      if (sif.line_start === 1'b1) lcount++;
      if (sif.frame_start === 1'b1) begin
        fcount++;
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != HTS * VTS * K) begin
            errors++; $display("FAIL frame_len got=%0d want=%0d", i - last_fs, HTS * VTS * K);
          end
        end
        last_fs = i;
      end
    end
    checks++;
    if (fcount != 4) begin errors++; $display("FAIL frame_pulses got=%0d want=4", fcount); end
    checks++;
    if (lcount != 4 * VTS) begin errors++; $display("FAIL line_pulses got=%0d want=%0d", lcount, 4 * VTS); end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 3000; i++) begin
      step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
      checks++;
      if (obs_d !== exp_d) begin errors++; $display("FAIL rand_d i=%0d got=%h want=%h", i, obs_d, exp_d); end
      checks++;
      if (obs_s !== exp_s) begin errors++; $display("FAIL rand_s i=%0d got=%h want=%h", i, obs_s, exp_s); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (p_s / HTS != 7 && n < 1000) begin step(0, 0, 1); n++; end
    checks++;
    if (sif.vsync !== 1'b0) begin errors++; $display("FAIL vs_active got=%b want=0", sif.vsync); end
    step(1, 0, 1);
    checks++;
    if (obs_s !== exp_s || sif.vsync !== 1'b1) begin
      errors++; $display("FAIL rst_mid_s got=%h want=%h", obs_s, exp_s);
    end
    step(0, 0, 0);
    n = 0;
    while (p_d % HTD != 300 && n < 2000 * K) begin step(0, 1, 0); n++; end
    step(1, 1, 0);
    checks++;
    if (obs_d !== {10'd799, 10'd524, 5'b11000}) begin
      errors++; $display("FAIL rst_mid_d got=%h want=%h", obs_d, {10'd799, 10'd524, 5'b11000});
    end
    n = 0;
    step(0, 1, 1);
    while (!fs_d && n < 4) begin step(0, 1, 1); n++; end
    checks++;
    if (obs_d !== {10'd0, 10'd0, 5'b11111}) begin
      errors++; $display("FAIL rst_mid_restart got=%h want=%h", obs_d, {10'd0, 10'd0, 5'b11111});
    end
  endtask

  initial begin
    dif.en = 1'b0;
    sif.en = 1'b0;
    test_reset();
    test_first_lines();
    test_freeze();
    test_frame_count();
    test_random_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
